// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings, FSM states, iteration count.
// Op codes mirror RV funct3 so the decoder can pass them through unchanged.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic int n_iter(input int xlen, input int step_bits);
    return xlen / step_bits;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 step on a {hi, lo} accumulator: add-or-skip for multiply, subtract-or-restore for divide.
// Purely combinational; chained STEP_BITS deep inside muldiv, no handshake of its own.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_out
);

  logic [XLEN:0] sum;
  logic [XLEN:0] top;
  logic [XLEN:0] diff;

  always_comb begin
    sum  = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    // Partial remainder shifted left with the next dividend bit pulled in from the low half.
    top  = acc_in[2*XLEN-1:XLEN-1];
    diff = top - {1'b0, opnd};
    if (is_div)
      acc_out = {(diff[XLEN] ? top[XLEN-1:0] : diff[XLEN-1:0]), acc_in[XLEN-2:0], ~diff[XLEN]};
    else
      acc_out = {sum, acc_in[XLEN-1:1]};
  end

endmodule

// File: rtl/muldiv.sv
// muldiv: iterative RV32M/RV64M unit; busy high N+1 cycles (1 on div-by-zero/overflow with MULDIV_EARLY_OUT_EN).
// No backpressure: dropping available mid-op aborts; result and fault hold in DONE until available falls.
module muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            available,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic [XLEN-1:0] out,
  output logic            busy,
  output logic            fault
);

  localparam int N  = n_iter(XLEN, STEP_BITS);
  localparam int CW = $clog2(N + 1);

  logic [1:0]          state;
  logic [CW-1:0]       cnt;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN-1:0]     opnd;
  logic                neg_res;
  logic                neg_rem;
  op_e                 op_q;

  logic                is_div, a_sgn, b_sgn, a_neg, b_neg, b_zero;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                early_go;
  logic [2*XLEN-1:0]   early_acc;

  assign is_div = op[2];
  assign a_sgn  = (op[2:0] != OP_MULHU) && (op[2:0] != OP_DIVU) && (op[2:0] != OP_REMU);
  assign b_sgn  = a_sgn && (op[2:0] != OP_MULHSU);
  assign a_neg  = a_sgn & in_a[XLEN-1];
  assign b_neg  = b_sgn & in_b[XLEN-1];
  assign a_mag  = a_neg ? -in_a : in_a;
  assign b_mag  = b_neg ? -in_b : in_b;
  assign b_zero = (in_b == '0);

`ifdef MULDIV_EARLY_OUT_EN
  logic ovf;
  assign ovf       = a_sgn && (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);
  assign early_go  = is_div & (b_zero | ovf);
  // Preload the final {remainder, quotient} magnitudes so FIX applies the normal sign rules.
  assign early_acc = b_zero ? {a_mag, {XLEN{1'b1}}} : {{XLEN{1'b0}}, a_mag};
`else
  assign early_go  = 1'b0;
  assign early_acc = '0;
`endif

  logic [2*XLEN-1:0] chain [0:STEP_BITS];
  assign chain[0] = acc;

  for (genvar g = 0; g < STEP_BITS; g++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div  (op_q[2]),
      .acc_in  (chain[g]),
      .opnd    (opnd),
      .acc_out (chain[g+1])
    );
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, res;

  always_comb begin
    prod = neg_res ? -acc : acc;
    quo  = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                       res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              res = quo;
      default:                      res = rem;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      op_q    <= OP_MUL;
      out     <= '0;
      busy    <= 1'b0;
      fault   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (available) begin
          if (op[3]) begin
            fault <= 1'b1;
            state <= ST_DONE;
          end else begin
            op_q    <= op_e'(op[2:0]);
            // A zero divisor keeps the all-ones quotient positive regardless of operand signs.
            neg_res <= (a_neg ^ b_neg) & ~(is_div & b_zero);
            neg_rem <= a_neg;
            opnd    <= is_div ? b_mag : a_mag;
            acc     <= early_go ? early_acc
                                : {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= early_go ? ST_FIX : ST_CALC;
          end
        end
        ST_CALC: if (!available) begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end else begin
          acc <= chain[STEP_BITS];
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          busy  <= 1'b0;
          if (!available) begin
            state <= ST_IDLE;
          end else begin
            out   <= res;
            state <= ST_DONE;
          end
        end
        default: if (!available) begin
          fault <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
